// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: RTC chip model on the multiplexed a_d/cs/rd/wr/dato bus, BCD time/date/timer bank.
// Latency: writes commit SYNC_STAGES+1 clocks after wr rises; read data is combinational from raw strobes.
// Backpressure: none, so the initiator must meet strobe widths. RTC_RESP_LEAP_YEAR_EN gives a 29-day Feb in leap years.
module rtc_bus_responder #(
  parameter int TICK_CYCLES = 100000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_d,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  inout  wire  [7:0] dato,
  output logic       irq,
  output logic       tick
);

`ifdef RTC_RESP_LEAP_YEAR_EN
  localparam bit LEAP_EN = 1'b1;
`else
  localparam bit LEAP_EN = 1'b0;
`endif

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  // Sync vector layout: {a_d, cs, rd, wr, dato[7:0]}; strobes reset inactive so no false edges.
  localparam logic [11:0] SYNC_RST = {1'b0, 1'b1, 1'b1, 1'b1, 8'h00};

  typedef enum logic [1:0] {IDLE, WPH, RPH} bus_state_t;

  bus_state_t   state;
  logic [11:0]  sync_q [SYNC_STAGES];
  logic [11:0]  raw_in;
  logic         ad_s, cs_s, rd_s, wr_s;
  logic [7:0]   dat_s;
  logic         rd_q, wr_q;
  logic         wr_fall, wr_rise, rd_fall, rd_rise;
  logic         data_commit, clr_done;
  logic [7:0]   addr;
  logic [CW-1:0] tick_cnt;

  logic [7:0]   sec, min_r, hour, day, month, year, wday;
  logic [7:0]   tsec, tmin, thour;
  logic         run, done;

  logic [7:0]   sec_n, min_n, hour_n, day_n, month_n, year_n, wday_n, mdays;
  logic [7:0]   tsec_n, tmin_n, thour_n;
  logic         c_sec, c_min, c_hour, c_day, c_month;
  logic         run_t, done_set;
  logic [7:0]   rdata;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // BCD increment within [lo, hi]; invalid or out-of-range values land on lo.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    if (!bcd_ok(v) || (v < lo) || (v >= hi)) return lo;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD decrement; zero borrows up to hi, garbage is pulled back to hi.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] hi);
    if (v == 8'h00) return hi;
    if (!bcd_ok(v) || (v > hi)) return hi;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Last day of the month in BCD; tens-digit parity decides divisibility by 4.
  function automatic logic [7:0] month_days(input logic [7:0] mon, input logic [7:0] yr);
    logic leap;
    leap = yr[4] ? (yr[3:0] inside {4'd2, 4'd6}) : (yr[3:0] inside {4'd0, 4'd4, 4'd8});
    case (mon)
      8'h02:                      return (LEAP_EN && leap) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  assign raw_in = {a_d, cs, rd, wr, dato};
  assign {ad_s, cs_s, rd_s, wr_s, dat_s} = sync_q[SYNC_STAGES-1];
  assign wr_fall = wr_q & ~wr_s;
  assign wr_rise = ~wr_q & wr_s;
  assign rd_fall = rd_q & ~rd_s;
  assign rd_rise = ~rd_q & rd_s;
  assign data_commit = (state == WPH) && !cs_s && wr_rise && ad_s;
  assign clr_done = data_commit && (addr == 8'h00) && dat_s[1];
  assign mdays = month_days(month, year);
  assign irq = done;

  // Synchronizer chain for all bus inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Bus phase FSM: tracks write/read phases and latches the address on address-phase commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addr  <= 8'h00;
      wr_q  <= 1'b1;
      rd_q  <= 1'b1;
    end else begin
      wr_q <= wr_s;
      rd_q <= rd_s;
      case (state)
        IDLE: begin
          if (!cs_s && wr_fall) state <= WPH;
          else if (!cs_s && ad_s && rd_fall) state <= RPH;
        end
        WPH: begin
          if (cs_s) begin
            state <= IDLE;
          end else if (wr_rise) begin
            state <= IDLE;
            if (!ad_s) addr <= dat_s;
          end
        end
        RPH: begin
          if (cs_s || rd_rise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-second tick generator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (tick_cnt == CW'(TICK_CYCLES - 1)) begin
      tick_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      tick     <= 1'b0;
    end
  end

  // Next calendar values for one second of advance; carries come from the current values.
  always_comb begin
    sec_n   = bcd_inc(sec, 8'h00, 8'h59);
    c_sec   = (sec_n == 8'h00);
    min_n   = min_r;
    hour_n  = hour;
    day_n   = day;
    wday_n  = wday;
    month_n = month;
    year_n  = year;
    c_min   = 1'b0;
    c_hour  = 1'b0;
    c_day   = 1'b0;
    c_month = 1'b0;
    if (c_sec) begin
      min_n = bcd_inc(min_r, 8'h00, 8'h59);
      c_min = (min_n == 8'h00);
    end
    if (c_min) begin
      hour_n = bcd_inc(hour, 8'h00, 8'h23);
      c_hour = (hour_n == 8'h00);
    end
    if (c_hour) begin
      day_n  = bcd_inc(day, 8'h01, mdays);
      wday_n = bcd_inc(wday, 8'h01, 8'h07);
      c_day  = (day_n == 8'h01);
    end
    if (c_day) begin
      month_n = bcd_inc(month, 8'h01, 8'h12);
      c_month = (month_n == 8'h01);
    end
    if (c_month) year_n = bcd_inc(year, 8'h00, 8'h99);
  end

  // Next countdown value; expiry sets DONE and stops the timer.
  always_comb begin
    tsec_n   = tsec;
    tmin_n   = tmin;
    thour_n  = thour;
    run_t    = run;
    done_set = 1'b0;
    if (run) begin
      if ({thour, tmin, tsec} != 24'h0) begin
        tsec_n = bcd_dec(tsec, 8'h59);
        if (tsec == 8'h00) begin
          tmin_n = bcd_dec(tmin, 8'h59);
          if (tmin == 8'h00) thour_n = bcd_dec(thour, 8'h99);
        end
        if ({thour_n, tmin_n, tsec_n} == 24'h0) begin
          done_set = 1'b1;
          run_t    = 1'b0;
        end
      end else begin
        run_t = 1'b0;
      end
    end
  end

  // Register bank: tick advance first, bus write to the addressed register overrides it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec <= 8'h00; min_r <= 8'h00; hour <= 8'h00; year <= 8'h00;
      day <= 8'h01; month <= 8'h01; wday <= 8'h01;
      tsec <= 8'h00; tmin <= 8'h00; thour <= 8'h00;
      run <= 1'b0; done <= 1'b0;
    end else begin
      if (tick) begin
        sec <= sec_n; min_r <= min_n; hour <= hour_n; day <= day_n;
        month <= month_n; year <= year_n; wday <= wday_n;
        tsec <= tsec_n; tmin <= tmin_n; thour <= thour_n;
        run <= run_t;
      end
      done <= (tick && done_set) || (done && !clr_done);
      if (data_commit) begin
        case (addr)
          8'h00: run   <= dat_s[0];
          8'h21: sec   <= dat_s;
          8'h22: min_r <= dat_s;
          8'h23: hour  <= dat_s;
          8'h24: day   <= dat_s;
          8'h25: month <= dat_s;
          8'h26: year  <= dat_s;
          8'h27: wday  <= dat_s;
          8'h41: tsec  <= dat_s;
          8'h42: tmin  <= dat_s;
          8'h43: thour <= dat_s;
          default: ;
        endcase
      end
    end
  end

  // Read mux for the latched address; unmapped locations read as zero.
  always_comb begin
    rdata = 8'h00;
    case (addr)
      8'h00: rdata = {6'b0, done, run};
      8'h21: rdata = sec;
      8'h22: rdata = min_r;
      8'h23: rdata = hour;
      8'h24: rdata = day;
      8'h25: rdata = month;
      8'h26: rdata = year;
      8'h27: rdata = wday;
      8'h41: rdata = tsec;
      8'h42: rdata = tmin;
      8'h43: rdata = thour;
      default: rdata = 8'h00;
    endcase
  end

  assign dato = (!reset && !cs && !rd && a_d) ? rdata : 8'hzz;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb_rtc_bus_responder: directed bus transactions against an integer-arithmetic RTC model.
// Checks tick/irq/dato every cycle plus literal expectations for the key scenarios.
// Bus transactions are scheduled inside tick windows so model and DUT event order agree.
module tb_rtc_bus_responder;
  localparam int T = 200;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_d = 1'b0, cs = 1'b1, rd = 1'b1, wr = 1'b1;
  logic [7:0] drv = 8'h00;
  logic       drv_en = 1'b0;
  wire  [7:0] dato;
  logic       irq, tick;

  int ntests = 0;
  int nfail = 0;

  // Model state
  int         n = 0;
  bit         m_tick = 1'b0;
  logic [7:0] m_r [0:255];
  logic [7:0] m_addr = 8'h00;
  bit         m_run = 1'b0, m_done = 1'b0;
  bit         busy = 1'b0;

  assign dato = drv_en ? drv : 8'hzz;

  rtc_bus_responder #(.TICK_CYCLES(T), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
    .dato(dato), .irq(irq), .tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1);
  end

  function automatic int b2i(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] i2b(input int x);
    logic [3:0] hi, lo;
    hi = 4'(x / 10);
    lo = 4'(x % 10);
    return {hi, lo};
  endfunction

  function automatic int mlen(input int mo, input int y);
    case (mo)
`ifdef RTC_RESP_LEAP_YEAR_EN
      2: return (y % 4 == 0) ? 29 : 28;
`else
      2: return (y >= 0) ? 28 : 28;
`endif
      4, 6, 9, 11: return 30;
      default: return 31;
    endcase
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h00: return {6'b0, m_done, m_run};
      8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h41, 8'h42, 8'h43: return m_r[a];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    case (a)
      8'h00: begin m_run = d[0]; if (d[1]) m_done = 1'b0; end
      8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h41, 8'h42, 8'h43: m_r[a] = d;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_r[i] = 8'h00;
    m_r[8'h24] = 8'h01; m_r[8'h25] = 8'h01; m_r[8'h27] = 8'h01;
    m_addr = 8'h00; m_run = 1'b0; m_done = 1'b0;
  endtask

  // One second of wall time plus one timer step, in plain integers.
  task automatic model_advance();
    int s, mi, h, d, mo, y, w, ml, t;
    bit c;
    s = b2i(m_r[8'h21]); mi = b2i(m_r[8'h22]); h = b2i(m_r[8'h23]);
    d = b2i(m_r[8'h24]); mo = b2i(m_r[8'h25]); y = b2i(m_r[8'h26]); w = b2i(m_r[8'h27]);
    ml = mlen(mo, y);
    s = s + 1; c = 1'b0;
    if (s >= 60) begin s = 0; c = 1'b1; end
    if (c) begin mi = mi + 1; c = 1'b0; if (mi >= 60) begin mi = 0; c = 1'b1; end end
    if (c) begin h = h + 1; c = 1'b0; if (h >= 24) begin h = 0; c = 1'b1; end end
    if (c) begin
      w = (w >= 7) ? 1 : w + 1;
      d = d + 1; c = 1'b0;
      if (d > ml) begin d = 1; c = 1'b1; end
    end
    if (c) begin mo = mo + 1; c = 1'b0; if (mo > 12) begin mo = 1; c = 1'b1; end end
    if (c) y = (y >= 99) ? 0 : y + 1;
    m_r[8'h21] = i2b(s); m_r[8'h22] = i2b(mi); m_r[8'h23] = i2b(h);
    m_r[8'h24] = i2b(d); m_r[8'h25] = i2b(mo); m_r[8'h26] = i2b(y); m_r[8'h27] = i2b(w);
    if (m_run) begin
      t = b2i(m_r[8'h43]) * 3600 + b2i(m_r[8'h42]) * 60 + b2i(m_r[8'h41]);
      if (t > 0) begin
        t = t - 1;
        m_r[8'h43] = i2b(t / 3600);
        m_r[8'h42] = i2b((t / 60) % 60);
        m_r[8'h41] = i2b(t % 60);
        if (t == 0) begin m_done = 1'b1; m_run = 1'b0; end
      end else begin
        m_run = 1'b0;
      end
    end
  endtask

  // Model clocking: tick expected after every T-th edge, time advances on the edge after it.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n = 0;
      m_tick = 1'b0;
      model_reset();
    end else begin
      n = n + 1;
      if (m_tick) model_advance();
      m_tick = (n % T == 0);
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Per-cycle comparison of tick, irq and the bus against the model.
  always @(negedge clk) begin
    logic [7:0] exp;
    #1;
    check("tick", {7'b0, tick}, {7'b0, m_tick});
    if (!busy) check("irq", {7'b0, irq}, {7'b0, m_done});
    if (!drv_en) begin
      ntests++;
      if (!reset && !cs && !rd && a_d) begin
        exp = model_read(m_addr);
        if (dato !== exp) begin
          nfail++;
          $display("FAIL dato_read: got %h, expected %h", dato, exp);
        end
      end else if (dato !== 8'hzz) begin
        nfail++;
        $display("FAIL dato_idle: got %h, expected zz", dato);
      end
    end
  end

  task automatic wait_window(input int len);
    int g;
    g = 0;
    while (((n % T) < 2 || (n % T) > T - len) && g < 4 * T) begin
      @(negedge clk);
      g++;
    end
    ntests++;
    if (g >= 4 * T) begin
      nfail++;
      $display("FAIL wait_window: waited %0d cycles, required < %0d", g, 4 * T);
    end
  endtask

  task automatic wait_advance();
    int g;
    g = 0;
    @(negedge clk);
    while ((n % T) != 2 && g < 4 * T) begin
      @(negedge clk);
      g++;
    end
    ntests++;
    if (g >= 4 * T) begin
      nfail++;
      $display("FAIL wait_advance: waited %0d cycles, required < %0d", g, 4 * T);
    end
  endtask

  task automatic bus_phase(input logic ad, input logic [7:0] v);
    busy = 1'b1;
    @(negedge clk); a_d = ad; drv = v; drv_en = 1'b1; cs = 1'b0;
    @(negedge clk); wr = 1'b0;
    repeat (S + 2) @(negedge clk);
    wr = 1'b1;
    repeat (S + 2) @(negedge clk);
    if (!ad) m_addr = v;
    else model_write(m_addr, v);
    cs = 1'b1; drv_en = 1'b0;
    @(negedge clk);
    busy = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_phase(1'b0, a);
    bus_phase(1'b1, d);
  endtask

  task automatic wr_w(input logic [7:0] a, input logic [7:0] d);
    wait_window(40);
    bus_write(a, d);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    bus_phase(1'b0, a);
    @(negedge clk); a_d = 1'b1; cs = 1'b0; rd = 1'b0;
    repeat (S + 3) @(negedge clk);
    d = dato;
    rd = 1'b1;
    @(negedge clk); cs = 1'b1;
    @(negedge clk);
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_tick", {7'b0, tick}, 8'h00);
    ntests++;
    if (dato !== 8'hzz) begin nfail++; $display("FAIL rst_dato: got %h, expected zz", dato); end

    // Reset values of the date and status registers.
    wait_window(110);
    read_chk("rst_day", 8'h24, 8'h01);
    read_chk("rst_month", 8'h25, 8'h01);
    read_chk("rst_wday", 8'h27, 8'h01);
    read_chk("rst_year", 8'h26, 8'h00);
    read_chk("rst_status", 8'h00, 8'h00);

    // Basic write/readback and unmapped address.
    wait_window(50);
    bus_write(8'h22, 8'h37);
    read_chk("min_rb", 8'h22, 8'h37);
    wait_window(50);
    bus_write(8'h30, 8'h55);
    read_chk("unmapped", 8'h30, 8'h00);

    // Full carry chain from 23:59:59 31 Dec 99, Sunday.
    wr_w(8'h21, 8'h00);
    wr_w(8'h26, 8'h99);
    wr_w(8'h25, 8'h12);
    wr_w(8'h24, 8'h31);
    wr_w(8'h27, 8'h07);
    wr_w(8'h23, 8'h23);
    wr_w(8'h22, 8'h59);
    wr_w(8'h21, 8'h59);
    wait_advance();
    read_chk("carry_sec", 8'h21, 8'h00);
    read_chk("carry_min", 8'h22, 8'h00);
    read_chk("carry_hour", 8'h23, 8'h00);
    read_chk("carry_day", 8'h24, 8'h01);
    read_chk("carry_month", 8'h25, 8'h01);
    read_chk("carry_year", 8'h26, 8'h00);
    read_chk("carry_wday", 8'h27, 8'h01);

    // Timer from 2 s to expiry, then clear DONE.
    wr_w(8'h41, 8'h02);
    wr_w(8'h42, 8'h00);
    wr_w(8'h43, 8'h00);
    wr_w(8'h00, 8'h01);
    wait_advance();
    wait_advance();
    #1;
    check("tmr_irq", {7'b0, irq}, 8'h01);
    read_chk("tmr_tsec", 8'h41, 8'h00);
    read_chk("tmr_tmin", 8'h42, 8'h00);
    read_chk("tmr_thour", 8'h43, 8'h00);
    read_chk("tmr_status", 8'h00, 8'h02);
    wr_w(8'h00, 8'h02);
    #1;
    check("tmr_irq_clr", {7'b0, irq}, 8'h00);

    // Borrow across hours: 01:00:00 -> 00:59:59.
    wr_w(8'h41, 8'h00);
    wr_w(8'h42, 8'h00);
    wr_w(8'h43, 8'h01);
    wr_w(8'h00, 8'h01);
    wait_advance();
    bus_write(8'h00, 8'h00);
    read_chk("brw_thour", 8'h43, 8'h00);
    read_chk("brw_tmin", 8'h42, 8'h59);
    read_chk("brw_tsec", 8'h41, 8'h59);

    // February end in year 24.
    wr_w(8'h21, 8'h00);
    wr_w(8'h26, 8'h24);
    wr_w(8'h25, 8'h02);
    wr_w(8'h24, 8'h28);
    wr_w(8'h23, 8'h23);
    wr_w(8'h22, 8'h59);
    wr_w(8'h21, 8'h59);
    wait_advance();
    read_chk("feb_hour", 8'h23, 8'h00);
`ifdef RTC_RESP_LEAP_YEAR_EN
    read_chk("feb_day", 8'h24, 8'h29);
    read_chk("feb_month", 8'h25, 8'h02);
`else
    read_chk("feb_day", 8'h24, 8'h01);
    read_chk("feb_month", 8'h25, 8'h03);
`endif

    // Write aborted by cs rising while wr is still low.
    wait_window(100);
    bus_write(8'h21, 8'h10);
    busy = 1'b1;
    bus_phase(1'b0, 8'h21);
    busy = 1'b1;
    @(negedge clk); a_d = 1'b1; drv = 8'h45; drv_en = 1'b1; cs = 1'b0;
    @(negedge clk); wr = 1'b0;
    repeat (S + 2) @(negedge clk);
    cs = 1'b1;
    repeat (S + 2) @(negedge clk);
    wr = 1'b1;
    repeat (S + 2) @(negedge clk);
    drv_en = 1'b0;
    @(negedge clk);
    busy = 1'b0;
    read_chk("abort_sec", 8'h21, 8'h10);

    // Reset in the middle of a read.
    wait_window(50);
    bus_phase(1'b0, 8'h24);
    @(negedge clk); a_d = 1'b1; cs = 1'b0; rd = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    ntests++;
    if (dato !== 8'hzz) begin nfail++; $display("FAIL rst_read_dato: got %h, expected zz", dato); end
    repeat (2) @(negedge clk);
    rd = 1'b1; cs = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst2_irq", {7'b0, irq}, 8'h00);
    wait_window(100);
    read_chk("rst2_day", 8'h24, 8'h01);
    read_chk("rst2_month", 8'h25, 8'h01);
    read_chk("rst2_hour", 8'h23, 8'h00);
    read_chk("rst2_status", 8'h00, 8'h00);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/rtc_bus_responder.md
Name: rtc_bus_responder

Overview:
- Cycle-accurate model of the external RTC chip, sitting on the far side of the multiplexed a_d/cs/rd/wr/dato bus.
- Used for FPGA loopback and simulation of the RTC controller, and as a stand-in when the chip is absent.
- Decodes address and data phases and holds the time, date and countdown-timer register bank in BCD.
- Advances time once per tick and raises an interrupt when the countdown timer expires.

Parameters:
- TICK_CYCLES, 100000000, clk cycles per 1-second tick (minimum 4).
- SYNC_STAGES, 2, flip-flop stages on the asynchronous bus inputs a_d, cs, rd, wr and dato.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- a_d  in  1  bus phase select: 0 = address, 1 = data.
- cs  in  1  chip select, active low.
- rd  in  1  read strobe, active low.
- wr  in  1  write strobe, active low.
- dato  inout  8  multiplexed address/data bus.
- irq  out  1  timer-done flag; equals STATUS[1].
- tick  out  1  one-cycle pulse per second.

Behaviour:
- Reset values:
  - dato released (Z); irq=0; tick=0; addr latch=0x00.
  - SEC/MIN/HOUR/YEAR=0x00; DAY/MONTH/WDAY=0x01; timer regs=0x00; STATUS=0x00.
  - Bus FSM in IDLE; tick counter=0.
- Register map:
  - 0x00 STATUS: bit0 RUN (rw), bit1 DONE (write 1 to clear).
  - 0x21 SEC, 0x22 MIN, 0x23 HOUR (24 h), 0x24 DAY, 0x25 MONTH, 0x26 YEAR, 0x27 WDAY (1-7).
  - 0x41 TSEC, 0x42 TMIN, 0x43 THOUR.
  - Unmapped: reads return 0x00; writes are ignored.
- Bus FSM states: IDLE, WPH, RPH. All transitions use the synchronized inputs.
  - IDLE -> WPH: cs=0 and wr falls.
  - IDLE -> RPH: cs=0, a_d=1 and rd falls.
  - WPH -> IDLE on wr rise. The commit happens in that same cycle:
    - a_d=0: addr <= synced dato.
    - a_d=1: reg[addr] <= synced dato.
  - RPH -> IDLE on rd rise.
  - In WPH or RPH, cs rising aborts to IDLE with no commit.
  - rd and wr both low in IDLE: the write wins and rd is ignored.
- Read path:
  - dato = reg[addr] combinationally while raw cs=0, rd=0 and a_d=1; otherwise Z.
  - The initiator must hold rd low for at least SYNC_STAGES+2 cycles and sample before rd rises.
- Tick:
  - Counter runs 0..TICK_CYCLES-1; tick pulses on wrap.
- Timekeeping on tick, BCD carry chain:
  - SEC 59->00 carries into MIN.
  - MIN 59->00 carries into HOUR.
  - HOUR 23->00 carries into DAY and WDAY; WDAY 7->1.
  - DAY past the month length ->01 carries into MONTH.
  - MONTH 12->01 carries into YEAR.
  - YEAR 99->00.
  - Month lengths: 31/28/31/30/31/30/31/31/30/31/30/31.
  - Any non-BCD or out-of-range value wraps to its minimum and generates a carry.
- Timer on tick with RUN=1:
  - Count nonzero: decrement THOUR:TMIN:TSEC in BCD with borrow (00->59).
  - Count reaching 00:00:00 sets DONE and clears RUN.
  - RUN=1 with count already zero: RUN clears on the next tick; DONE is unchanged.
- Simultaneous events:
  - A bus commit and a tick in the same cycle: the bus write wins for the addressed register. Other registers update normally, and carries are computed from the pre-write values.
  - DONE set and DONE cleared in the same cycle: set wins.
- Reset mid-transaction: immediate return to reset values, bus released.

Optional Feature:
- Macro: RTC_RESP_LEAP_YEAR_EN.
  - Defined: February has 29 days when YEAR (BCD) is divisible by 4, including 00.
  - Undefined: February always has 28 days.

Test Plan:
- Address 0x22 then write data 0x37, then read back at 0x22 -> dato=0x37 during rd low; the bus is Z outside rd.
- Preload 23:59:59, DAY 0x31, MONTH 0x12, YEAR 0x99, WDAY 7, then one tick -> 00:00:00, DAY 0x01, MONTH 0x01, YEAR 0x00, WDAY 1.
- TSEC=0x02, others 0, STATUS=0x01, two ticks -> timer reads 00:00:00, irq=1, STATUS=0x02; write 0x02 to STATUS -> irq=0.
- Timer set to 01:00:00 and running, one tick -> THOUR 0x00, TMIN 0x59, TSEC 0x59.
- cs deasserted mid-write (wr still low) to 0x21 with 0x45 -> SEC unchanged. Reset asserted during a read -> dato Z and registers at reset values.
- With TICK_CYCLES=4, date 28 Feb YEAR 0x24, HOUR 23:59:59, one tick -> DAY 0x29 when RTC_RESP_LEAP_YEAR_EN is defined; 0x01/MONTH 0x03 when it is not.
